// File: rtl/piano_pkg.sv
// Shared constants and types for the keyboard-to-frame-transmitter path.
// The ASCII table fixes the key count.
package piano_pkg;

  localparam int NUM_KEYS = 13;

  typedef logic [9:0] frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  localparam logic FRAME_START = 1'b0;
  localparam logic FRAME_STOP  = 1'b1;

  localparam logic [7:0] KEY_ASCII [NUM_KEYS] = '{
    8'h43, 8'h63, 8'h44, 8'h64, 8'h45, 8'h46, 8'h66,
    8'h47, 8'h67, 8'h41, 8'h61, 8'h42, 8'h43
  };

  function automatic frame_t make_frame(input logic [7:0] ascii);
    return {FRAME_STOP, ascii, FRAME_START};
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus tick-sampled debounce for every key.
// Emits a one-cycle press pulse one cycle after a key's stable level rises.
module key_debouncer #(
  parameter int NUM_KEYS        = 13,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tick_s;
  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] sample_q, sample_d;
  logic [NUM_KEYS-1:0] stable_q, stable_d, stable_dly_q;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] agree_s;

  // Next-state for the shared tick counter and the per-key debounce history
  always_comb begin
    tick_s   = (cnt_q == CNT_LAST);
    cnt_d    = tick_s ? '0 : cnt_q + CW'(1);
    agree_s  = ~(sync2_q ^ sample_q);
    // stable only follows two consecutive identical tick samples
    sample_d = tick_s ? sync2_q : sample_q;
    stable_d = tick_s ? ((sync2_q & agree_s) | (stable_q & ~agree_s)) : stable_q;
  end

  // Synchronizer, debounce state and press-edge register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sample_q     <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      press_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      sync1_q      <= keys_i;
      sync2_q      <= sync1_q;
      sample_q     <= sample_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_event_arbiter.sv
// Latches debounced key presses as pending events and sends one ASCII frame
// at a time to the serial-frame transmitter, granting keys round-robin.
module key_event_arbiter
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] keyboard,
  input  logic                tx_ready,
  output logic                tx_valid,
  output logic [9:0]          tx_data,
  output logic [NUM_KEYS-1:0] pending,
  output logic                busy,
  output logic                overflow
);

  logic [NUM_KEYS-1:0] press_s;
  logic [NUM_KEYS-1:0] clr_s;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic                overflow_q, overflow_d;
  arb_state_t          state_q;
  logic [3:0]          rr_ptr_q, rr_next_s, grant_idx_s;
  logic                grant_valid_s;
  frame_t              tx_data_q;
  logic                tx_valid_q, busy_q;

  key_debouncer #(
    .NUM_KEYS        (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset_n (reset_n),
    .keys_i  (keyboard),
    .press_o (press_s)
  );

  // Round-robin search: walk offsets downward so the nearest set bit wins
  always_comb begin
    logic [4:0] cand;
    grant_valid_s = 1'b0;
    grant_idx_s   = 4'd0;
    cand          = 5'd0;
    for (int off = NUM_KEYS - 1; off >= 0; off--) begin
      cand          = {1'b0, rr_ptr_q} + 5'(off);
      cand          = (cand >= 5'(NUM_KEYS)) ? cand - 5'(NUM_KEYS) : cand;
      grant_valid_s = grant_valid_s | pending_q[cand[3:0]];
      grant_idx_s   = pending_q[cand[3:0]] ? cand[3:0] : grant_idx_s;
    end
    rr_next_s = (grant_idx_s == 4'(NUM_KEYS - 1)) ? 4'd0 : grant_idx_s + 4'd1;
  end

  // Pending/overflow next-state; a new press beats a same-cycle grant clear
  always_comb begin
    clr_s      = ((state_q == IDLE) && grant_valid_s)
               ? ({{(NUM_KEYS-1){1'b0}}, 1'b1} << grant_idx_s) : '0;
    pending_d  = (pending_q & ~clr_s) | press_s;
    overflow_d = overflow_q | (|(press_s & pending_q & ~clr_s));
  end

  // Pending event and sticky overflow registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Grant/send FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 4'd0;
      tx_data_q  <= 10'h000;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid_s) begin
            tx_data_q  <= make_frame(KEY_ASCII[grant_idx_s]);
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            rr_ptr_q   <= rr_next_s;
            state_q    <= SEND;
          end else begin
            state_q    <= IDLE;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            state_q    <= SEND;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign pending  = pending_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: doc/key_event_arbiter.md
# key_event_arbiter

Sequences key-press events from the 13-key keyboard onto the shared 10-bit serial-frame transmitter interface. Each raw key input is synchronized and debounced, and each press edge is latched as a pending event. A round-robin arbiter then issues one framed ASCII code at a time over a valid/ready handshake. The block sits between the keyboard pins and the frame transmitter, and replaces ad-hoc combinational driving of the transmitter input.

## Interface
- NUM_KEYS, 13, number of keys; fixed by the ASCII table in the package.
- DEBOUNCE_CYCLES, 50000, clk cycles between debounce samples; minimum 2.
- clk  input  1  system clock.
- reset_n  input  1  reset, synchronous, active-low.
- keyboard  input  NUM_KEYS  raw, asynchronous key levels; 1 = pressed.
- tx_ready  input  1  transmitter can accept a frame.
- tx_valid  output  1  tx_data holds a frame to transfer.
- tx_data  output  10  frame {stop=1, ascii[7:0], start=0}.
- pending  output  NUM_KEYS  press events queued but not yet granted.
- busy  output  1  FSM in SEND.
- overflow  output  1  sticky flag: a press was lost; cleared only by reset.

## Operation
- **Synchronizer:** each keyboard bit passes through 2 flops.
- **Debounce:**
  - A shared counter counts 0..DEBOUNCE_CYCLES-1 and pulses `tick` on wrap.
  - On each tick, every key's synchronized level is sampled.
  - stable[i] takes the new sample only when it equals the previous tick's sample.
  - Glitches shorter than one tick period never change stable.
- **Press edge:** stable[i] goes 0->1; registered one cycle after the stable update.
- **pending[i]:**
  - Set on a press edge.
  - Cleared when key i is granted.
  - A set and a clear in the same cycle: set wins.
  - A press edge on a key whose pending is already 1 and not being cleared sets overflow. The event merges, so only one frame is sent.
- **Releases:** generate no frame.
- **FSM states:**
  - IDLE: if pending is nonzero, grant the first set bit searching upward from rr_ptr, wrapping 12->0. In that cycle: load tx_data with the frame for the granted key, clear its pending bit, set rr_ptr = (grant+1) mod 13, go to SEND.
  - SEND: tx_valid=1. On tx_valid && tx_ready, go to IDLE.
- **ASCII codes** (index -> code): 0:0x43, 1:0x63, 2:0x44, 3:0x64, 4:0x45, 5:0x46, 6:0x66, 7:0x47, 8:0x67, 9:0x41, 10:0x61, 11:0x42, 12:0x43.
- **Reset values:**
  - Outputs: tx_valid=0, tx_data=10'h000, pending=0, busy=0, overflow=0.
  - Internal: rr_ptr=0, stable=0, sample history=0, debounce counter=0, FSM=IDLE.

## Timing
- pending[i] is first visible in cycle N. IDLE grants at the end of cycle N. tx_valid=1 from cycle N+1.
- tx_data and tx_valid must stay stable while tx_valid=1 && tx_ready=0. tx_valid never drops without a handshake, except on reset.
- Handshake in cycle M: tx_valid=0 in cycle M+1, which is spent in IDLE. The earliest next tx_valid is cycle M+2. Minimum spacing is 2 cycles per frame.
- tx_ready high before tx_valid is legal and has no effect.
- Worst-case key-to-frame latency: 2 sync cycles + 2 ticks + 1 edge cycle + 1 grant cycle + wait for earlier grants.
- Reset during SEND: tx_valid=0 on the next cycle. The in-flight frame and all pending events are discarded.
- The debounce counter runs in all FSM states. Sampling is never stalled by backpressure.

## Structure
- Package `piano_pkg` holds:
  - `NUM_KEYS`
  - `KEY_ASCII[NUM_KEYS]` table
  - `FRAME_START` (1'b0) and `FRAME_STOP` (1'b1)
  - typedef `frame_t` (logic [9:0])
  - FSM enum `arb_state_t` {IDLE, SEND}
- Sub-module `key_debouncer`: synchronizer, shared tick counter, stable register and press-edge outputs, parameterized by NUM_KEYS and DEBOUNCE_CYCLES.
- Arbiter, pending register and FSM stay in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Single press:** press key 0 and hold, tx_ready=1 -> exactly one frame, tx_data=10'h286, tx_valid high for 1 cycle. Releasing key 0 produces no frame.
- **Simultaneous press, arbitration:** keys 3 and 9 pressed in the same cycle after reset -> frame 10'h2C8 (key 3), then 10'h282 (key 9), spaced 2 cycles. rr_ptr=10 afterwards. Pressing keys 9 and 10 then yields key 10 first (0x2C2).
- **Backpressure:** press key 10 with tx_ready=0 for 20 cycles -> tx_valid=1 and tx_data=10'h2C2 constant for all 20 cycles. Transfer completes on the first tx_ready=1 cycle.
- **Bounce:** key 4 high for 3 cycles (shorter than a tick) -> no pending bit, no frame. Then held high for 12 cycles -> one frame with ascii 0x45.
- **Overflow:** key 0 in SEND with tx_ready=0; key 5 pressed, released and pressed again (each level held 12 cycles) -> overflow=1, pending[5]=1. After release of tx_ready, exactly one 0x46 frame is sent.
- **Reset mid-operation:** reset_n=0 for 1 cycle while in SEND with pending[2]=1 -> next cycle tx_valid=0, pending=0, overflow=0, tx_data=10'h000. No frame for key 2.
